small_alu_pack: RTL
===================

Name: small_alu_pack

Overview:
- Parametrised successor of the packed small-secret coefficient multiplier in the Saber polynomial-multiply datapath.
- Per accepted sample, takes two public coefficients (a0, a1) and two small sign-magnitude secrets (s0, s1) and computes three mod-2^LOGQ products: a0*s0, a0*s1+a1*s0, a1*s1.
- Adds: valid handshake, configurable pipeline depth, per-sample negation for negacyclic wrap, and an optional per-lane accumulator for schoolbook MAC.
- Sits between the coefficient/secret fetch logic and the result memory write-back.

Parameters:
- LOGQ, 13, coefficient and result width; all arithmetic is mod 2^LOGQ.
- SW, 4, secret width: bit SW-1 is sign, bits SW-2:0 are magnitude.
- LAT, 4, cycles from in_valid to out_valid; legal range 2..8.
- ACC_EN, 1, 1 = accumulate results across samples; 0 = plain product outputs.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  sample present this cycle
- a0  in  LOGQ  coefficient 0, unsigned
- a1  in  LOGQ  coefficient 1, unsigned
- s0  in  SW  secret 0, sign-magnitude
- s1  in  SW  secret 1, sign-magnitude
- neg  in  1  negate all three products of this sample
- acc_clr  in  1  this sample starts a new accumulation
- out_valid  out  1  r0..r2 updated this cycle
- r0  out  LOGQ  (accumulated) a0*s0
- r1  out  LOGQ  (accumulated) a0*s1+a1*s0
- r2  out  LOGQ  (accumulated) a1*s1

Behaviour:
- Reset (async assert, sync release): all pipeline valid bits, accumulators, r0..r2 and out_valid go to 0 immediately. A sample in flight at reset is discarded and never produces out_valid.
- Secret decode: value = (-1)^sign * magnitude, range ±(2^(SW-1)-1). Negative zero (sign=1, magnitude=0) equals 0 and must not produce a -0 adjust error.
- Products: p0 = a0*s0, p1 = a0*s1 + a1*s0, p2 = a1*s1, all taken mod 2^LOGQ. If neg=1, each pk becomes (2^LOGQ - pk) mod 2^LOGQ.
- Packing:
  - Both coefficients may share one wide multiplier using guard-bit packing, with sign correction applied after the multiply.
  - Results must be bit-exact to the formula above for every input, including a0 or a1 = 2^LOGQ-1 and maximum-magnitude secrets.
  - Borrow across packed fields must be corrected.
- Pipeline and handshake:
  - Fully pipelined; one sample accepted per cycle, no backpressure.
  - in_valid, neg and acc_clr travel with the data. out_valid asserts exactly LAT cycles after the accepting edge.
  - Bubbles (in_valid=0) propagate as bubbles.
  - a0, a1, s0, s1, neg and acc_clr are don't-care when in_valid=0.
- Output update, ACC_EN=0: on out_valid, rk <= pk; otherwise rk holds its value.
- Output update, ACC_EN=1: on out_valid, rk <= pk if the sample's acc_clr=1, else rk <= rk + pk mod 2^LOGQ. rk holds between valid samples.
- Simultaneous events:
  - acc_clr on a sample while an earlier accumulation is still draining: earlier samples finish into the old sum first, then the clearing sample loads.
  - Back-to-back acc_clr samples each load fresh.
- First sample after reset accumulates onto 0, so it is equivalent to acc_clr=1.
- Accumulator wrap past 2^LOGQ-1 is silent modulo wrap; no overflow flag.

Test Plan:
- LAT=4, ACC_EN=0: a0=5, a1=7, s0=4'b0011 (+3), s1=4'b1010 (-2), in_valid for 1 cycle -> out_valid exactly 4 cycles later with r0=15, r1=11, r2=8178.
- Wrap and neg: a0=8191, a1=0, s0=+7, s1=0 -> r0=8185, r1=0, r2=0. Same inputs with neg=1 -> r0=7.
- Negative zero: s0=4'b1000, s1=4'b1000, a0=a1=1234 -> r0=r1=r2=0.
- ACC_EN=1, three consecutive samples (a0=1, a1=2, s0=+1, s1=+1), first with acc_clr=1 -> after the third out_valid r0=3, r1=9, r2=6. A fourth sample with acc_clr=1, neg=1 -> r0=8191, r1=8189, r2=8190.
- Throughput: 64 back-to-back random samples with random bubbles -> out_valid pattern equals in_valid delayed by LAT, and every result matches the reference model.
- Reset mid-stream: assert rst 2 cycles after accepting a sample -> outputs and out_valid are 0 immediately, no out_valid from the dropped sample, and the next sample after release accumulates from 0.

Source files
------------

// File: rtl/small_alu_pack.sv
// Pipelined small-secret coefficient multiplier: three mod-2^LOGQ products per sample,
// optional negation and optional per-lane accumulation, out_valid exactly LAT cycles after accept.
module small_alu_pack #(
  parameter int LOGQ   = 13,
  parameter int SW     = 4,
  parameter int LAT    = 4,
  parameter int ACC_EN = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [LOGQ-1:0] a0,
  input  logic [LOGQ-1:0] a1,
  input  logic [SW-1:0]   s0,
  input  logic [SW-1:0]   s1,
  input  logic            neg,
  input  logic            acc_clr,
  output logic            out_valid,
  output logic [LOGQ-1:0] r0,
  output logic [LOGQ-1:0] r1,
  output logic [LOGQ-1:0] r2
);

  typedef struct packed {
    logic            v;
    logic            clr;
    logic [LOGQ-1:0] p0;
    logic [LOGQ-1:0] p1;
    logic [LOGQ-1:0] p2;
  } stage_t;

  // Signed product of an unsigned coefficient and a sign-magnitude secret; -0 negates 0 to 0.
  function automatic logic [LOGQ-1:0] smul(input logic [LOGQ-1:0] a, input logic [SW-1:0] s);
    logic [LOGQ-1:0] m;
    m = LOGQ'(a * {{(LOGQ-SW+1){1'b0}}, s[SW-2:0]});
    if (s[SW-1]) smul = {LOGQ{1'b0}} - m;
    else         smul = m;
  endfunction

  logic            v_r;
  logic            clr_r;
  logic            neg_r;
  logic [LOGQ-1:0] a0_r;
  logic [LOGQ-1:0] a1_r;
  logic [SW-1:0]   s0_r;
  logic [SW-1:0]   s1_r;
  stage_t          prod_s;
  stage_t          pipe [LAT-1];
  stage_t          last_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_r   <= 1'b0;
      clr_r <= 1'b0;
      neg_r <= 1'b0;
      a0_r  <= {LOGQ{1'b0}};
      a1_r  <= {LOGQ{1'b0}};
      s0_r  <= {SW{1'b0}};
      s1_r  <= {SW{1'b0}};
    end else begin
      v_r   <= in_valid;
      clr_r <= acc_clr;
      neg_r <= neg;
      a0_r  <= a0;
      a1_r  <= a1;
      s0_r  <= s0;
      s1_r  <= s1;
    end
  end

  always_comb begin
    prod_s     = '0;
    prod_s.v   = v_r;
    prod_s.clr = clr_r;
    prod_s.p0  = smul(a0_r, s0_r);
    prod_s.p1  = smul(a0_r, s1_r) + smul(a1_r, s0_r);
    prod_s.p2  = smul(a1_r, s1_r);
    if (neg_r) begin
      prod_s.p0 = {LOGQ{1'b0}} - prod_s.p0;
      prod_s.p1 = {LOGQ{1'b0}} - prod_s.p1;
      prod_s.p2 = {LOGQ{1'b0}} - prod_s.p2;
    end else begin
      prod_s.p0 = prod_s.p0;
    end
  end

  // Delay line padding the datapath out to LAT cycles; bubbles travel as v=0 entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT-1; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= prod_s;
      for (int i = 1; i < LAT-1; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign last_s = pipe[LAT-2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      r0        <= {LOGQ{1'b0}};
      r1        <= {LOGQ{1'b0}};
      r2        <= {LOGQ{1'b0}};
    end else if (last_s.v) begin
      out_valid <= 1'b1;
      if (ACC_EN == 0 || last_s.clr) begin
        r0 <= last_s.p0;
        r1 <= last_s.p1;
        r2 <= last_s.p2;
      end else begin
        r0 <= r0 + last_s.p0;
        r1 <= r1 + last_s.p1;
        r2 <= r2 + last_s.p2;
      end
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule
